// File: rtl/boot_load_sequencer.sv
// Program-load sequencer for the UART boot path: debounces start_pg, holds the CPU in reset
// during a load, steers loader writes to ROM or data RAM and releases the CPU when loading ends.
module boot_load_sequencer #(
  parameter int unsigned DEB_CYC      = 1000000,
  parameter int unsigned DRAIN_CYC    = 16,
  parameter int unsigned LOAD_TIMEOUT = 0
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start_pg,
  input  logic        upg_wen_i,
  input  logic [14:0] upg_adr_i,
  input  logic        upg_done_i,
  output logic        upg_rst_o,
  output logic        cpu_rst_o,
  output logic        rom_wen_o,
  output logic        dmem_wen_o,
  output logic        load_active_o,
  output logic [15:0] words_loaded_o,
  output logic        load_err_o
);

  localparam int DW  = $clog2(DEB_CYC + 1);
  localparam int DRW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int IW  = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_RUN   = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [DW-1:0]    deb_q, deb_d;
  logic             armed_q, armed_d;
  logic [DRW-1:0]   drain_q, drain_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [15:0]      words_q, words_d;
  logic             err_q, err_d;
  logic             trigger;
  logic             in_load;
  logic             timeout_hit;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= S_HOLD;
      deb_q   <= '0;
      armed_q <= 1'b0;
      drain_q <= '0;
      idle_q  <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= start_pg;
      sync2_q <= sync1_q;
      state_q <= state_d;
      deb_q   <= deb_d;
      armed_q <= armed_d;
      drain_q <= drain_d;
      idle_q  <= idle_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

  // Trigger is level-qualified by armed, so a held button fires exactly once.
  assign trigger     = armed_q && (deb_q == DW'(DEB_CYC));
  assign in_load     = (state_q == S_LOAD);
  assign timeout_hit = (LOAD_TIMEOUT != 0) && (idle_q == IW'(LOAD_TIMEOUT - 1));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    armed_d = armed_q;
    drain_d = drain_q;
    idle_d  = idle_q;
    words_d = words_q;
    err_d   = err_q;

    if (!sync2_q) begin
      deb_d = '0;
    end else if (deb_q != DW'(DEB_CYC)) begin
      deb_d = deb_q + 1'b1;
    end

    if (trigger) begin
      armed_d = 1'b0;
    end else if (!sync2_q) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      S_HOLD: state_d = S_RUN;
      S_RUN, S_ERR: begin
        if (trigger) begin
          state_d = S_LOAD;
          words_d = '0;
          idle_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (upg_wen_i) begin
          idle_d = '0;
          if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
        // Done outranks timeout; a write in the same cycle suppresses timeout.
        if (upg_done_i) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else if (!upg_wen_i && timeout_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRW'(DRAIN_CYC - 1)) begin
          state_d = S_RUN;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  assign rom_wen_o      = in_load && upg_wen_i && !upg_adr_i[14];
  assign dmem_wen_o     = in_load && upg_wen_i &&  upg_adr_i[14];
  assign load_active_o  = in_load || (state_q == S_DRAIN);
  assign upg_rst_o      = !load_active_o;
  assign cpu_rst_o      = (state_q != S_RUN);
  assign words_loaded_o = words_q;
  assign load_err_o     = err_q;

endmodule
